// File: rtl/qos_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qos_pkg
//  Brief    : Shared defaults and grant-decoding helpers for the QoS
//             FIFO pop multiplexer.
//  Revision : 1.0 - initial release
// ============================================================================
package qos_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  // Grant vectors are zero-extended to 32 bits, so 5 index bits cover any N_CH.
  localparam int IDX_W_MAX  = 5;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  // Binary index of the set bit; meaningful only for a one-hot input.
  function automatic logic [IDX_W_MAX-1:0] onehot_to_idx(input logic [31:0] v);
    logic [IDX_W_MAX-1:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = idx | IDX_W_MAX'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qos_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : qos_sat_counter
//  Brief    : Saturating event counter with synchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
module qos_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/qos_fifo_pop_mux.sv
`default_nettype none
// ============================================================================
//  Module   : qos_fifo_pop_mux
//  Brief    : Pops one class FIFO per accepted arbiter grant, follows the pop
//             through the FIFO read latency, and pushes the returned word into
//             the principal FIFO. Tracks grant errors and per-channel pops.
//  Revision : 1.0 - initial release
// ============================================================================
module qos_fifo_pop_mux
  import qos_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET_L,
  input  logic                   POP_REQ,
  input  logic [N_CH-1:0]        GRANT,
  input  logic [N_CH-1:0]        FIFO_EMPTY,
  input  logic [N_CH*DATA_W-1:0] FIFO_DATA,
  input  logic                   MAIN_ALMOST_FULL,
  input  logic                   CNT_CLR,
  output logic [N_CH-1:0]        FIFO_POP,
  output logic                   POP_ACK,
  output logic                   PUSH_MAIN,
  output logic [DATA_W-1:0]      MAIN_DATA,
  output logic                   BUSY,
  output logic                   GRANT_ERR,
  output logic [N_CH*CNT_W-1:0]  POP_CNT
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              w_grant_ok;
  logic              w_hit_empty;
  logic              w_fire;
  logic [IDX_W-1:0]  w_idx;
  logic              w_cap_vld;
  logic [IDX_W-1:0]  w_cap_idx;
  logic              w_inflight;
  logic [DATA_W-1:0] w_cap_data;

  logic              r_push;
  logic [DATA_W-1:0] r_main_data;
  logic              r_busy;
  logic              r_grant_err;

  // Accept only a clean one-hot grant on a non-empty FIFO with room downstream.
  assign w_grant_ok  = is_onehot(32'(GRANT));
  assign w_hit_empty = |(GRANT & FIFO_EMPTY);
  assign w_fire      = RESET_L & POP_REQ & w_grant_ok & ~w_hit_empty & ~MAIN_ALMOST_FULL;
  assign w_idx       = IDX_W'(onehot_to_idx(32'(GRANT)));

  assign POP_ACK  = w_fire;
  assign FIFO_POP = {N_CH{w_fire}} & GRANT;

  if (RD_LAT == 0) begin : g_lat0
    // First-word-fall-through: the word is on FIFO_DATA in the pop cycle.
    assign w_cap_vld  = w_fire;
    assign w_cap_idx  = w_idx;
    assign w_inflight = 1'b0;
  end else begin : g_latn
    logic [RD_LAT-1:0] r_vld;
    logic [IDX_W-1:0]  r_idx [RD_LAT];

    // Delay line carrying {valid, channel} until the FIFO data is ready.
    always_ff @(posedge CLK) begin
      if (!RESET_L) begin
        r_vld <= '0;
      end else begin
        r_vld[0] <= w_fire;
        for (int k = 1; k < RD_LAT; k++) r_vld[k] <= r_vld[k-1];
      end
      r_idx[0] <= w_idx;
      for (int k = 1; k < RD_LAT; k++) r_idx[k] <= r_idx[k-1];
    end

    assign w_cap_vld  = r_vld[RD_LAT-1];
    assign w_cap_idx  = r_idx[RD_LAT-1];
    assign w_inflight = |r_vld;
  end

  assign w_cap_data = FIFO_DATA[w_cap_idx*DATA_W +: DATA_W];

  // Output stage: register the captured word and its push strobe.
  // BUSY is registered from the next-cycle view of the pipeline and push.
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      r_push      <= 1'b0;
      r_main_data <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_push <= w_cap_vld;
      if (w_cap_vld) r_main_data <= w_cap_data;
      r_busy <= w_fire | w_inflight;
    end
  end

  // Sticky flag for a request carrying a zero or multi-bit grant.
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      r_grant_err <= 1'b0;
    end else if (CNT_CLR) begin
      r_grant_err <= 1'b0;
    end else if (POP_REQ && !w_grant_ok) begin
      r_grant_err <= 1'b1;
    end
  end

  assign PUSH_MAIN = r_push;
  assign MAIN_DATA = r_main_data;
  assign BUSY      = r_busy;
  assign GRANT_ERR = r_grant_err;

  for (genvar i = 0; i < N_CH; i++) begin : g_cnt
    qos_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (CLK),
      .rst_n (RESET_L),
      .i_clr (CNT_CLR),
      .i_inc (FIFO_POP[i]),
      .o_cnt (POP_CNT[i*CNT_W +: CNT_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_qos_fifo_pop_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qos_fifo_pop_mux
//  Brief    : Self-checking bench for qos_fifo_pop_mux (RD_LAT=1, CNT_W=3)
//             with registered-read class FIFO models and a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qos_fifo_pop_mux;

  localparam int NC = 4;
  localparam int DW = 4;
  localparam int RL = 1;
  localparam int CW = 3;

  logic           CLK = 1'b0;
  logic           RESET_L;
  logic           POP_REQ;
  logic [NC-1:0]  GRANT;
  logic [NC-1:0]  FIFO_EMPTY;
  logic [NC*DW-1:0] FIFO_DATA;
  logic           MAIN_ALMOST_FULL;
  logic           CNT_CLR;
  logic [NC-1:0]  FIFO_POP;
  logic           POP_ACK;
  logic           PUSH_MAIN;
  logic [DW-1:0]  MAIN_DATA;
  logic           BUSY;
  logic           GRANT_ERR;
  logic [NC*CW-1:0] POP_CNT;

  qos_fifo_pop_mux #(
    .N_CH   (NC),
    .DATA_W (DW),
    .RD_LAT (RL),
    .CNT_W  (CW)
  ) dut (
    .CLK              (CLK),
    .RESET_L          (RESET_L),
    .POP_REQ          (POP_REQ),
    .GRANT            (GRANT),
    .FIFO_EMPTY       (FIFO_EMPTY),
    .FIFO_DATA        (FIFO_DATA),
    .MAIN_ALMOST_FULL (MAIN_ALMOST_FULL),
    .CNT_CLR          (CNT_CLR),
    .FIFO_POP         (FIFO_POP),
    .POP_ACK          (POP_ACK),
    .PUSH_MAIN        (PUSH_MAIN),
    .MAIN_DATA        (MAIN_DATA),
    .BUSY             (BUSY),
    .GRANT_ERR        (GRANT_ERR),
    .POP_CNT          (POP_CNT)
  );

  always #5 CLK = ~CLK;

  // Class FIFO models: contents plus the registered read port.
  logic [DW-1:0] q [NC][$];
  logic [DW-1:0] fdata [NC];

  // Words expected at the principal FIFO, tagged with the cycle they appear.
  typedef struct {
    int            due;
    logic [DW-1:0] w;
  } pend_t;
  pend_t pend[$];

  int            cyc;
  int            cnt [NC];
  logic          exp_gerr;
  logic [DW-1:0] last_md;
  int            n_cmp;
  int            n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic apply_fifo();
    for (int i = 0; i < NC; i++) begin
      FIFO_DATA[i*DW +: DW] = fdata[i];
      FIFO_EMPTY[i]         = (q[i].size() == 0);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    exp_gerr = 1'b0;
    last_md  = '0;
  endtask

  // One clock cycle: check outputs against the model, clock, update model.
  task automatic tick(input logic refill);
    logic             exp_fire;
    logic             granted_empty;
    logic             exp_push;
    int               ch;
    logic [NC*CW-1:0] exp_cnt;
    logic [DW-1:0]    w;
    #1;
    granted_empty = 1'b0;
    ch = 0;
    for (int i = 0; i < NC; i++) begin
      if (GRANT[i]) begin
        ch = i;
        if (q[i].size() == 0) granted_empty = 1'b1;
      end
    end
    exp_fire = RESET_L && POP_REQ && $onehot(GRANT) && !granted_empty && !MAIN_ALMOST_FULL;

    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
    exp_push = (pend.size() > 0 && pend[0].due == cyc);
    if (exp_push) last_md = pend[0].w;
    for (int i = 0; i < NC; i++) exp_cnt[i*CW +: CW] = CW'(cnt[i]);

    chk("fifo_pop",  32'(FIFO_POP),  exp_fire ? 32'(GRANT) : 32'd0);
    chk("pop_ack",   32'(POP_ACK),   32'(exp_fire));
    chk("push_main", 32'(PUSH_MAIN), 32'(exp_push));
    chk("main_data", 32'(MAIN_DATA), 32'(last_md));
    chk("busy",      32'(BUSY),      32'(pend.size() > 0));
    chk("grant_err", 32'(GRANT_ERR), 32'(exp_gerr));
    chk("pop_cnt",   32'(POP_CNT),   32'(exp_cnt));

    @(posedge CLK);
    #1;
    if (!RESET_L) begin
      model_reset();
    end else begin
      if (CNT_CLR) begin
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        exp_gerr = 1'b0;
      end else begin
        if (POP_REQ && !$onehot(GRANT)) exp_gerr = 1'b1;
        if (exp_fire && cnt[ch] < (1 << CW) - 1) cnt[ch]++;
      end
      if (exp_fire) begin
        w = q[ch].pop_front();
        fdata[ch] = w;
        pend.push_back('{due: cyc + RL + 1, w: w});
      end
    end
    if (refill) begin
      for (int i = 0; i < NC; i++)
        if ($urandom_range(0, 3) == 0) q[i].push_back(DW'($urandom));
    end
    apply_fifo();
    cyc++;
  endtask

  task automatic idle(input int n);
    POP_REQ = 1'b0;
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    model_reset();
    for (int i = 0; i < NC; i++) begin
      fdata[i] = '0;
      for (int k = 0; k < 48; k++) q[i].push_back(DW'($urandom));
    end
    q[2][0] = 4'hA;
    apply_fifo();

    // Reset held with an active request
    RESET_L = 1'b0; POP_REQ = 1'b1; GRANT = 4'b0001;
    MAIN_ALMOST_FULL = 1'b0; CNT_CLR = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) tick(1'b0);
    RESET_L = 1'b1;
    idle(1);

    // Single transfer on channel 2 (head word 4'hA)
    POP_REQ = 1'b1; GRANT = 4'b0100;
    tick(1'b0);
    idle(3);
    chk("main_data_A", 32'(MAIN_DATA), 32'h0000_000A);
    chk("cnt2_one",    32'(POP_CNT[2*CW +: CW]), 32'd1);

    // Streaming with rotating grants
    for (int i = 0; i < 8; i++) begin
      POP_REQ = 1'b1;
      GRANT   = NC'(1 << (i % NC));
      tick(1'b0);
    end
    idle(4);

    // Granted FIFO empty: request dropped
    q[1].delete();
    apply_fifo();
    POP_REQ = 1'b1; GRANT = 4'b0010;
    tick(1'b0);
    idle(2);
    for (int k = 0; k < 16; k++) q[1].push_back(DW'($urandom));
    apply_fifo();

    // Almost-full blocks new pops while in-flight words drain
    POP_REQ = 1'b1; GRANT = 4'b0001; tick(1'b0);
    GRANT = 4'b0010; tick(1'b0);
    MAIN_ALMOST_FULL = 1'b1; GRANT = 4'b0100; tick(1'b0); tick(1'b0);
    MAIN_ALMOST_FULL = 1'b0;
    idle(3);

    // Bad grants set the sticky error; clear removes it
    POP_REQ = 1'b1; GRANT = 4'b0011; tick(1'b0);
    GRANT = 4'b0000; tick(1'b0);
    idle(2);
    CNT_CLR = 1'b1; tick(1'b0);
    CNT_CLR = 1'b0;
    idle(1);

    // Saturation on channel 0
    for (int i = 0; i < 9; i++) begin
      POP_REQ = 1'b1; GRANT = 4'b0001;
      tick(1'b0);
    end
    idle(3);
    chk("cnt0_sat", 32'(POP_CNT[0 +: CW]), 32'd7);

    // Reset one cycle after a pop discards it
    POP_REQ = 1'b1; GRANT = 4'b1000; tick(1'b0);
    POP_REQ = 1'b0; RESET_L = 1'b0; tick(1'b0);
    RESET_L = 1'b1;
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      POP_REQ          = ($urandom_range(0, 3) != 0);
      GRANT            = ($urandom_range(0, 9) < 8) ? NC'(1 << $urandom_range(0, NC - 1))
                                                    : NC'($urandom);
      MAIN_ALMOST_FULL = ($urandom_range(0, 4) == 0);
      CNT_CLR          = ($urandom_range(0, 29) == 0);
      RESET_L          = ($urandom_range(0, 49) != 0);
      tick(1'b1);
    end
    RESET_L = 1'b1; CNT_CLR = 1'b0; MAIN_ALMOST_FULL = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
